// File: rtl/instr_loader.sv
// Boot loader: packs a framed byte stream into 32-bit words, writes them to instruction memory, then releases core reset.
// Optional trailing XOR checksum byte enabled by defining INSTR_LOADER_CHECKSUM_EN.
module instr_loader #(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              mem_we_re,
    output logic              mem_request,
    output logic [3:0]        mem_mask,
    output logic [ADDR_W-1:0] mem_address,
    output logic [31:0]       mem_data_out,
    input  logic              mem_valid,
    output logic              core_rst,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int unsigned CNT_W = 9;
    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

    typedef enum logic [2:0] {
        S_IDLE, S_COUNT, S_BYTES, S_WRITE, S_CSUM, S_FINISH
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        bcnt_q, bcnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       data_q, data_d;
    logic              byte_ready_q, byte_ready_d;
    logic              req_q, req_d;
    logic [3:0]        mask_q, mask_d;
    logic              core_rst_q, core_rst_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
`ifdef INSTR_LOADER_CHECKSUM_EN
    logic [7:0]        csum_q, csum_d;
`endif
    logic              accept;

    assign accept       = byte_valid && byte_ready_q;
    assign byte_ready   = byte_ready_q;
    assign mem_request  = req_q;
    assign mem_we_re    = req_q;
    assign mem_mask     = mask_q;
    assign mem_address  = addr_q;
    assign mem_data_out = data_q;
    assign core_rst     = core_rst_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign error        = error_q;

    // Next state plus datapath; outputs are registered from the next state
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bcnt_d     = bcnt_q;
        addr_d     = addr_q;
        data_d     = data_q;
        core_rst_d = core_rst_q;
        error_d    = error_q;
`ifdef INSTR_LOADER_CHECKSUM_EN
        csum_d     = csum_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_COUNT;
                    core_rst_d = 1'b1;
                    error_d    = 1'b0;
                    addr_d     = BASE;
`ifdef INSTR_LOADER_CHECKSUM_EN
                    csum_d     = 8'd0;
`endif
                end
            end
            S_COUNT: begin
                if (accept) begin
                    cnt_d   = (byte_in == 8'd0) ? CNT_W'(256) : CNT_W'(byte_in);
                    bcnt_d  = 2'd0;
                    state_d = S_BYTES;
                end
            end
            S_BYTES: begin
                if (accept) begin
                    data_d = {byte_in, data_q[31:8]};
                    bcnt_d = bcnt_q + 2'd1;
`ifdef INSTR_LOADER_CHECKSUM_EN
                    csum_d = csum_q ^ byte_in;
`endif
                    if (bcnt_q == 2'd3) begin
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                if (mem_valid) begin
                    addr_d = addr_q + ADDR_W'(1);
                    cnt_d  = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
`ifdef INSTR_LOADER_CHECKSUM_EN
                        state_d = S_CSUM;
`else
                        state_d = S_FINISH;
`endif
                    end else begin
                        state_d = S_BYTES;
                    end
                end
            end
`ifdef INSTR_LOADER_CHECKSUM_EN
            S_CSUM: begin
                if (accept) begin
                    if (byte_in == csum_q) begin
                        state_d = S_FINISH;
                    end else begin
                        error_d = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
`endif
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase

        byte_ready_d = (state_d == S_COUNT) || (state_d == S_BYTES) || (state_d == S_CSUM);
        req_d        = (state_d == S_WRITE);
        mask_d       = req_d ? 4'b1111 : 4'b0000;
        busy_d       = byte_ready_d || req_d;
        done_d       = (state_d == S_FINISH);
        if (done_d) begin
            core_rst_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            bcnt_q       <= '0;
            addr_q       <= BASE;
            data_q       <= '0;
            byte_ready_q <= 1'b0;
            req_q        <= 1'b0;
            mask_q       <= 4'b0000;
            core_rst_q   <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
`ifdef INSTR_LOADER_CHECKSUM_EN
            csum_q       <= '0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bcnt_q       <= bcnt_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            byte_ready_q <= byte_ready_d;
            req_q        <= req_d;
            mask_q       <= mask_d;
            core_rst_q   <= core_rst_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            error_q      <= error_d;
`ifdef INSTR_LOADER_CHECKSUM_EN
            csum_q       <= csum_d;
`endif
        end
    end

endmodule

// File: tb/tb_instr_loader.sv
// Bench for instr_loader: two instances in lockstep (BASE_ADDR 0 and 8'hFE) driven by a byte-stream driver and memory responder.
module tb_instr_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, byte_valid, mem_valid;
    logic [7:0]  byte_in;

    logic        br0, we0, req0, crst0, busy0, done0, err0;
    logic [3:0]  mask0;
    logic [7:0]  addr0;
    logic [31:0] data0;
    logic        br1, we1, req1, crst1, busy1, done1, err1;
    logic [3:0]  mask1;
    logic [7:0]  addr1;
    logic [31:0] data1;

    instr_loader #(.ADDR_W(8), .BASE_ADDR(0)) u_dut0 (
        .clk(clk), .rst(rst), .start(start), .byte_in(byte_in), .byte_valid(byte_valid),
        .byte_ready(br0), .mem_we_re(we0), .mem_request(req0), .mem_mask(mask0),
        .mem_address(addr0), .mem_data_out(data0), .mem_valid(mem_valid),
        .core_rst(crst0), .busy(busy0), .done(done0), .error(err0)
    );

    instr_loader #(.ADDR_W(8), .BASE_ADDR(8'hFE)) u_dut1 (
        .clk(clk), .rst(rst), .start(start), .byte_in(byte_in), .byte_valid(byte_valid),
        .byte_ready(br1), .mem_we_re(we1), .mem_request(req1), .mem_mask(mask1),
        .mem_address(addr1), .mem_data_out(data1), .mem_valid(mem_valid),
        .core_rst(crst1), .busy(busy1), .done(done1), .error(err1)
    );

    typedef struct {
        logic [7:0]  a0;
        logic [7:0]  a1;
        logic [31:0] d;
    } wr_t;

    typedef struct {
        int              n;
        logic [3:0][31:0] w;
        int              delay;
        bit              gap;
        bit              spur;
    } vec_t;

    int  checks = 0;
    int  failures = 0;
    wr_t exp_q[$];
    wr_t ent;
    int  cyc = 0;
    int  mem_delay = 0;
    bit  spur = 1'b0;
    int  req_cnt = 0;
    bit  acked = 1'b0;
    logic [7:0]  cap_a;
    logic [31:0] cap_d;
    int  ack_cyc = 0;
    int  done_cnt = 0;
    vec_t vecs[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Memory responder and write scoreboard
    always @(negedge clk) begin
        if (done0) done_cnt++;
        chk("lockstep", {br1, we1, req1, mask1, crst1, busy1, done1, err1},
                        {br0, we0, req0, mask0, crst0, busy0, done0, err0});
        if (rst) begin
            mem_valid = 1'b0;
            req_cnt   = 0;
            acked     = 1'b0;
        end else if (req0) begin
            if (req_cnt == 0) begin
                cap_a = addr0;
                cap_d = data0;
            end else begin
                chk("addr_stable", addr0, cap_a);
                chk("data_stable", data0, cap_d);
            end
            chk("ready_in_write", br0, 1'b0);
            chk("mask_write", mask0, 4'hF);
            chk("we_write", we0, 1'b1);
            if (!acked && req_cnt >= mem_delay) begin
                acked     = 1'b1;
                mem_valid = 1'b1;
                ack_cyc   = cyc;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL stray_write: got write %0h @%0h expected none", data0, addr0);
                end else begin
                    ent = exp_q.pop_front();
                    chk("wr_addr", addr0, ent.a0);
                    chk("wr_addr_base_fe", addr1, ent.a1);
                    chk("wr_data", data0, ent.d);
                    chk("wr_data_base_fe", data1, ent.d);
                end
            end else begin
                mem_valid = 1'b0;
            end
            req_cnt++;
        end else begin
            mem_valid = spur;
            req_cnt   = 0;
            acked     = 1'b0;
            chk("mask_idle", mask0, 4'h0);
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit gap);
        int guard;
        if (gap) begin
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                byte_valid = 1'b0;
            end
        end
        @(negedge clk);
        byte_valid = 1'b1;
        byte_in    = b;
        guard      = 0;
        while (!br0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) begin
            checks++;
            failures++;
            $display("FAIL byte_ready_timeout: got 0 expected 1");
        end
        @(posedge clk);
        #1 byte_valid = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_byte_ready", br0, 1'b1);
        chk("start_busy", busy0, 1'b1);
        chk("start_core_rst", crst0, 1'b1);
        chk("start_error_clr", err0, 1'b0);
    endtask

    task automatic push_expected(input int n, input logic [3:0][31:0] w);
        wr_t e;
        for (int i = 0; i < n; i++) begin
            e.a0 = 8'(i);
            e.a1 = 8'(254 + i);
            e.d  = w[i];
            exp_q.push_back(e);
        end
    endtask

    task automatic send_payload(input int n, input logic [3:0][31:0] w, input bit gap);
        logic [31:0] wd;
        send_byte(8'(n), gap);
        for (int i = 0; i < n; i++) begin
            wd = w[i];
            for (int b = 0; b < 4; b++) send_byte(wd[8*b +: 8], gap);
        end
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        while (!done0 && k < 300) begin
            @(negedge clk);
            k++;
        end
        chk("done_seen", done0, 1'b1);
    endtask

    task automatic run_frame(input int n, input logic [3:0][31:0] w, input int delay, input bit gap);
`ifdef INSTR_LOADER_CHECKSUM_EN
        logic [7:0] x;
        logic [31:0] wd;
`endif
        mem_delay = delay;
        push_expected(n, w);
        pulse_start();
        send_payload(n, w, gap);
`ifdef INSTR_LOADER_CHECKSUM_EN
        x = 8'h00;
        for (int i = 0; i < n; i++) begin
            wd = w[i];
            x = x ^ wd[7:0] ^ wd[15:8] ^ wd[23:16] ^ wd[31:24];
        end
        send_byte(x, gap);
`endif
        wait_done();
        chk("done_core_rst", crst0, 1'b0);
        chk("done_busy", busy0, 1'b0);
        chk("writes_left", exp_q.size(), 0);
        chk("error_clear", err0, 1'b0);
`ifndef INSTR_LOADER_CHECKSUM_EN
        chk("done_latency", cyc, ack_cyc + 1);
`endif
        @(negedge clk);
        chk("done_pulse", done0, 1'b0);
        chk("core_rst_held_low", crst0, 1'b0);
    endtask

    initial begin
        int dc;
        logic [3:0][31:0] w;

        // Frame table: n, words (w[0] first), mem_valid delay, byte gaps, spurious mem_valid outside WRITE
        vecs[0].n = 2; vecs[0].w = {32'h0, 32'h0, 32'h00100093, 32'h00500013};
        vecs[0].delay = 0; vecs[0].gap = 1'b0; vecs[0].spur = 1'b0;
        vecs[1].n = 2; vecs[1].w = {32'h0, 32'h0, 32'h00100093, 32'h00500013};
        vecs[1].delay = 3; vecs[1].gap = 1'b1; vecs[1].spur = 1'b0;
        vecs[2].n = 3; vecs[2].w = {32'h0, 32'h0000FFFF, 32'hAABBCCDD, 32'h11223344};
        vecs[2].delay = 1; vecs[2].gap = 1'b1; vecs[2].spur = 1'b1;
        vecs[3].n = 1; vecs[3].w = {32'h0, 32'h0, 32'h0, 32'hDEADBEEF};
        vecs[3].delay = 0; vecs[3].gap = 1'b0; vecs[3].spur = 1'b0;

        rst = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_in = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_core_rst", crst0, 1'b1);
        chk("rst_byte_ready", br0, 1'b0);
        chk("rst_request", req0, 1'b0);
        chk("rst_we", we0, 1'b0);
        chk("rst_busy", busy0, 1'b0);
        chk("rst_done", done0, 1'b0);
        chk("rst_error", err0, 1'b0);
        chk("rst_mask", mask0, 4'h0);
        chk("rst_addr", addr0, 8'h00);
        chk("rst_addr_base_fe", addr1, 8'hFE);
        chk("rst_data", data0, 32'h0);

        // Idle with stray stream and memory activity
        spur = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            byte_valid = i[0];
            byte_in    = 8'hA5;
            chk("idle_core_rst", crst0, 1'b1);
            chk("idle_request", req0, 1'b0);
            chk("idle_byte_ready", br0, 1'b0);
        end
        spur = 1'b0;
        byte_valid = 1'b0;
        chk("idle_addr", addr0, 8'h00);

        for (int v = 0; v < 4; v++) begin
            spur = vecs[v].spur;
            run_frame(vecs[v].n, vecs[v].w, vecs[v].delay, vecs[v].gap);
            spur = 1'b0;
        end

        // Reset mid-word, then a fresh one-word frame
        mem_delay = 0;
        pulse_start();
        send_byte(8'd1, 1'b0);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_core_rst", crst0, 1'b1);
        chk("midrst_busy", busy0, 1'b0);
        chk("midrst_byte_ready", br0, 1'b0);
        chk("midrst_addr", addr0, 8'h00);
        chk("midrst_data", data0, 32'h0);
        dc = done_cnt;
        w = {32'h0, 32'h0, 32'h0, 32'hCAFEF00D};
        run_frame(1, w, 0, 1'b0);
        chk("midrst_done_once", done_cnt - dc, 1);

`ifdef INSTR_LOADER_CHECKSUM_EN
        // Correct checksum 22 for DEADBEEF
        w = {32'h0, 32'h0, 32'h0, 32'hDEADBEEF};
        mem_delay = 0;
        push_expected(1, w);
        pulse_start();
        send_payload(1, w, 1'b0);
        send_byte(8'h22, 1'b0);
        wait_done();
        chk("csum_ok_core_rst", crst0, 1'b0);
        chk("csum_ok_error", err0, 1'b0);
        @(negedge clk);

        // Wrong checksum 23
        push_expected(1, w);
        pulse_start();
        send_payload(1, w, 1'b0);
        dc = done_cnt;
        send_byte(8'h23, 1'b0);
        repeat (5) @(negedge clk);
        chk("csum_bad_error", err0, 1'b1);
        chk("csum_bad_core_rst", crst0, 1'b1);
        chk("csum_bad_busy", busy0, 1'b0);
        chk("csum_bad_no_done", done_cnt - dc, 0);
        chk("csum_bad_writes_left", exp_q.size(), 0);
        pulse_start();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
`endif

        repeat (3) @(negedge clk);
        chk("final_no_pending", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/instr_loader.md
# instr_loader

Boot-time program loader sitting directly upstream of the instruction memory. It accepts a framed byte stream from an external host, packs bytes little-endian into 32-bit instruction words and writes them into the instruction memory through its request/valid write port. It holds the core in reset until a complete program has been written. After that, the core fetches from the loaded image.

## Interface
Parameters:
- ADDR_W, 8: word-address width driven to instruction memory (256 words).
- BASE_ADDR, 0: word address of the first loaded instruction.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a load frame when idle.
- byte_in  in  8  stream data byte.
- byte_valid  in  1  byte_in valid.
- byte_ready  out  1  loader accepts byte this cycle.
- mem_we_re  out  1  instruction memory write enable; 1 = write.
- mem_request  out  1  instruction memory access request.
- mem_mask  out  4  byte-lane mask; 4'b1111 during writes, 4'b0000 otherwise.
- mem_address  out  ADDR_W  word address.
- mem_data_out  out  32  word to write.
- mem_valid  in  1  memory completed the current request.
- core_rst  out  1  reset to core; high while no valid image is loaded.
- busy  out  1  frame in progress.
- done  out  1  one-cycle pulse on successful completion.
- error  out  1  sticky; set on frame failure, cleared by rst or next start.

## Operation
- Frame format: byte 0 = word count N (0 encodes 256). Followed by 4N data bytes, least-significant byte of each word first.
- States:
  - IDLE → COUNT on start.
  - COUNT: accept one byte, latch N → BYTES.
  - BYTES: accept 4 bytes into the shift register → WRITE.
  - WRITE: drive mem_request=1, mem_we_re=1, mem_mask=4'b1111, mem_address, mem_data_out, held stable until mem_valid.
  - On mem_valid: increment address, decrement remaining count. If remaining is 0 → FINISH, else → BYTES.
  - FINISH: pulse done, drop core_rst → IDLE.
- Byte handshake: a byte transfers when byte_valid && byte_ready. byte_ready=1 only in COUNT and BYTES (and CSUM when enabled).
- Address starts at BASE_ADDR. It increments modulo 2^ADDR_W, so the 256-word frame with BASE_ADDR≠0 wraps to 0.
- start while busy: ignored.
- start in IDLE: sets core_rst=1, clears error and the checksum accumulator, and reloads the address to BASE_ADDR.
- mem_valid outside WRITE: ignored.

## Timing
- Reset values:
  - core_rst=1.
  - byte_ready, mem_request, mem_we_re, busy, done, error = 0.
  - mem_mask=0, mem_address=BASE_ADDR, mem_data_out=0.
- start sampled in cycle t → COUNT in t+1, with byte_ready high from t+1.
- Fourth byte of a word accepted in cycle t → mem_request high from t+1.
- mem_valid sampled high in cycle u → mem_request low in u+1. The next byte_ready is high in u+1.
- Minimum per word: 4 byte cycles + 1 write cycle when mem_valid returns in the same cycle as the request.
- Last write acknowledged at u → done=1 and core_rst=0 at u+1, busy=0 at u+1.
- busy=1 from cycle after start until done.
- rst mid-frame: immediate return to IDLE with reset values. core_rst re-asserts, and the partial image is considered invalid.

## Configuration
- INSTR_LOADER_CHECKSUM_EN defined:
  - Frame carries one extra trailing byte, the XOR of all 4N data bytes.
  - After the last write acknowledgement the FSM enters CSUM and accepts that byte.
  - Match → done pulse, core_rst=0.
  - Mismatch → error=1, no done, core_rst stays 1 → IDLE.
- Not defined:
  - No CSUM state; FINISH follows the last write directly.
  - error never sets.

## Test plan
- Reset, then idle: core_rst=1, mem_request=0, byte_ready=0 for 10 cycles with byte_valid=1 toggling.
- start; bytes 02,13,00,50,00,93,00,10,00 with mem_valid returned same cycle as request:
  - writes 32'h00500013 @0, then 32'h00100093 @1;
  - done pulse, core_rst=0.
- Same frame with mem_valid delayed 3 cycles per write, byte_valid gapped randomly:
  - mem_address/mem_data_out stable while request held;
  - byte_ready=0 during WRITE;
  - identical final memory.
- BASE_ADDR=8'hFE, N=3:
  - addresses FE, FF, 00 in order, no fourth write.
- rst asserted mid-word (after 2 data bytes), then a new 1-word frame:
  - no stray write;
  - word lands at BASE_ADDR;
  - done once.
- With INSTR_LOADER_CHECKSUM_EN, N=1, word 32'hDEADBEEF:
  - checksum 22 → done, core_rst=0;
  - checksum 23 → error=1, core_rst=1, no done.
